// File: rtl/cpu_controller.sv
// Instruction register, decoder and multi-cycle control FSM that sequences the datapath strobes.
// Optional HALT state for opcode 111 is compiled in when CTRL_HALT_EN is defined.
module cpu_controller (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        s,
   input  logic [15:0] in,
   output logic        w,
   output logic        halted,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic        write,
   output logic [3:0]  vsel,
   output logic [1:0]  ALUop,
   output logic [1:0]  shift,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [15:0] sximm5,
   output logic [15:0] sximm8
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_ALU,
      S_WRITE_REG
`ifdef CTRL_HALT_EN
      , S_HALT
`endif
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] ir_reg;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op, sh;
   logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_binary;

   assign opcode = ir_reg[15:13];
   assign op     = ir_reg[12:11];
   assign rn     = ir_reg[10:8];
   assign rd     = ir_reg[7:5];
   assign sh     = ir_reg[4:3];
   assign rm     = ir_reg[2:0];

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);
   assign is_binary  = is_alu && (op != 2'b11);

   assign sximm5 = {{11{ir_reg[4]}}, ir_reg[4:0]};
   assign sximm8 = {{8{ir_reg[7]}}, ir_reg[7:0]};

   // IR only accepts new words while idle, so a running instruction cannot be corrupted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_WAIT;
         ir_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_WAIT && load)
            ir_reg <= in;
      end
   end

   always_comb begin
      state_next = state_reg;
      w          = 1'b0;
      halted     = 1'b0;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      write      = 1'b0;
      vsel       = 4'b0000;
      ALUop      = 2'b00;
      shift      = 2'b00;
      readnum    = 3'b000;
      writenum   = 3'b000;
      case (state_reg)
         S_WAIT: begin
            w = 1'b1;
            if (s)
               state_next = S_DECODE;
         end
         S_DECODE: begin
            if (is_mov_imm)
               state_next = S_WRITE_IMM;
            else if (is_mov_reg || is_mvn)
               state_next = S_GET_B;
            else if (is_binary)
               state_next = S_GET_A;
`ifdef CTRL_HALT_EN
            else if (opcode == 3'b111)
               state_next = S_HALT;
`endif
            else
               state_next = S_WAIT;
         end
         S_WRITE_IMM: begin
            write      = 1'b1;
            writenum   = rn;
            vsel       = 4'b0010;
            state_next = S_WAIT;
         end
         S_GET_A: begin
            readnum    = rn;
            loada      = 1'b1;
            state_next = S_GET_B;
         end
         S_GET_B: begin
            readnum    = rm;
            loadb      = 1'b1;
            state_next = S_ALU;
         end
         S_ALU: begin
            // Unary ops route a zeroed A path through asel; CMP only updates status.
            shift      = sh;
            loadc      = !is_cmp;
            loads      = is_cmp;
            ALUop      = is_alu ? op : 2'b00;
            asel       = is_mov_reg || is_mvn;
            state_next = is_cmp ? S_WAIT : S_WRITE_REG;
         end
         S_WRITE_REG: begin
            write      = 1'b1;
            writenum   = rd;
            vsel       = 4'b1000;
            state_next = S_WAIT;
         end
`ifdef CTRL_HALT_EN
         S_HALT: begin
            halted     = 1'b1;
            state_next = S_HALT;
         end
`endif
         default: state_next = S_WAIT;
      endcase
   end

endmodule
